// File: rtl/wide_word_serializer_pkg.sv
// Shared widths, width derivations and FSM encoding for the wide word serializer.
package wide_word_serializer_pkg;

    localparam int unsigned WORD_W_DEF = 132;
    localparam int unsigned BEAT_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned calc_nbeats(input int unsigned word_w, input int unsigned beat_w);
        return (word_w + beat_w - 1) / beat_w;
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned nbeats);
        return (nbeats <= 1) ? 1 : $clog2(nbeats);
    endfunction

endpackage

// File: rtl/wide_word_serializer_if.sv
// Word-in / beat-out handshake bundle; slave is the serializer's view.
interface wide_word_serializer_if
    import wide_word_serializer_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF
);
    localparam int unsigned NBEATS = calc_nbeats(WORD_W, BEAT_W);
    localparam int unsigned IDX_W  = calc_idx_w(NBEATS);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

endinterface

// File: rtl/wide_word_serializer_beat_select.sv
// Picks beat idx out of the held word; the final partial beat is zero-extended.
module beat_select #(
    parameter int unsigned WORD_W = 132,
    parameter int unsigned BEAT_W = 32,
    parameter int unsigned NBEATS = 5,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [WORD_W-1:0] hold,
    input  logic [IDX_W-1:0]  idx,
    output logic [BEAT_W-1:0] beat
);
    logic [NBEATS*BEAT_W-1:0] padded;

    // Padding the word up to a whole number of beats gives the zero-extension for free.
    assign padded = (NBEATS*BEAT_W)'(hold);

    always_comb begin
        beat = '0;
        for (int unsigned i = 0; i < NBEATS; i++) begin
            if (idx == IDX_W'(i)) begin
                beat = padded[i*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: rtl/wide_word_serializer.sv
// Accepts one wide word over valid/ready and streams it out as narrow beats, low beat first.
module wide_word_serializer
    import wide_word_serializer_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF
) (
    input logic                   clk,
    input logic                   reset,
    wide_word_serializer_if.slave bus
);
    localparam int unsigned NBEATS = calc_nbeats(WORD_W, BEAT_W);
    localparam int unsigned IDX_W  = calc_idx_w(NBEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    state_t            state, state_nxt;
    logic [WORD_W-1:0] hold;
    logic [IDX_W-1:0]  idx;
    logic [BEAT_W-1:0] beat;
    logic              at_last;
    logic              in_xfer;
    logic              out_xfer;

    assign at_last  = (state == SEND) && (idx == LAST_IDX);
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = SEND;
            SEND: if (out_xfer && at_last && !bus.in_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.out_data  = '0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            SEND: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.out_data  = beat;
                bus.out_idx   = idx;
                bus.out_last  = at_last;
                // Reload on the last beat keeps back-to-back words gapless.
                bus.in_ready  = at_last && bus.out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
        end else if (in_xfer) begin
            hold <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (in_xfer || (out_xfer && at_last)) begin
            idx <= '0;
        end else if (out_xfer) begin
            idx <= idx + 1'b1;
        end
    end

    beat_select #(
        .WORD_W(WORD_W),
        .BEAT_W(BEAT_W),
        .NBEATS(NBEATS),
        .IDX_W (IDX_W)
    ) u_beat_select (
        .hold(hold),
        .idx (idx),
        .beat(beat)
    );

endmodule

// File: tb/tb_wide_word_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed beats, a negedge monitor pops and compares.
module tb_wide_word_serializer;

    logic clk = 1'b0;
    logic reset;

    wide_word_serializer_if #(.WORD_W(132), .BEAT_W(32)) bus();

    wide_word_serializer #(.WORD_W(132), .BEAT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam logic [131:0] W1 = 132'hA_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [131:0] W2 = 132'h5_44444444_33333333_22222222_11111111;
    localparam logic [131:0] WF = {4'hF, 128'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                             input logic [31:0] b3, input logic [31:0] b4);
        logic [31:0] b [5];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
        for (int i = 0; i < 5; i++) begin
            beat_t e;
            e.data = b[i];
            e.idx  = 3'(i);
            e.last = (i == 4);
            sb.push_back(e);
        end
    endtask

    // Monitor: every accepted beat must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h idx %0d, required no beat", bus.out_data, bus.out_idx);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_data", 64'(bus.out_data), 64'(e.data));
                chk("beat_idx",  64'(bus.out_idx),  64'(e.idx));
                chk("beat_last", 64'(bus.out_last), 64'(e.last));
            end
        end
    end

    task automatic offer(input logic [131:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int n = 0; n < 20; n++) begin
            if (bus.in_ready) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL offer_timeout: in_ready never 1, required handshake within 20 cycles");
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 40 && (sb.size() != 0 || bus.busy); n++) begin
            @(posedge clk); #1;
        end
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_busy", 64'(bus.busy), 64'd0);
        chk("drain_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"},      64'(bus.busy),      64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_out_data"},  64'(bus.out_data),  64'd0);
        chk({tag, "_out_idx"},   64'(bus.out_idx),   64'd0);
        chk({tag, "_out_last"},  64'(bus.out_last),  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100us");
        $fatal(1);
    end

    initial begin
        int vcnt;

        // Reset with random inputs
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = {4'($urandom), $urandom, $urandom, $urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #3;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Single word, full throughput
        push_word(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'h0000000A);
        offer(W1);
        chk("first_beat_valid", 64'(bus.out_valid), 64'd1);
        chk("first_beat_idx", 64'(bus.out_idx), 64'd0);
        wait_drain();

        // Backpressure on beat 2
        push_word(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'h0000000A);
        offer(W1);
        for (int n = 0; n < 10 && bus.out_idx != 3'd2; n++) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            bus.in_data = {4'h3, 128'h0} | 132'(n + 1);
            @(negedge clk);
            chk("bp_out_data",  64'(bus.out_data),  64'hCCCCCCCC);
            chk("bp_out_idx",   64'(bus.out_idx),   64'd2);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        // Back-to-back words with in_valid held
        push_word(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'h0000000A);
        bus.in_valid = 1'b1;
        bus.in_data  = W1;
        @(posedge clk); #1;
        bus.in_data = W2;
        push_word(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h00000005);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
            chk("b2b_in_ready", 64'(bus.in_ready), 64'((k % 5) == 4));
            @(posedge clk); #1;
            if (k == 4) bus.in_valid = 1'b0;
        end
        chk("b2b_valid_cycles", 64'(vcnt), 64'd10);
        @(negedge clk);
        chk("b2b_then_idle", 64'(bus.out_valid), 64'd0);
        wait_drain();

        // Reset mid-word, then a word with only the partial last beat set
        push_word(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'h0000000A);
        offer(W1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check_reset_values("midreset");
        @(posedge clk); #3;
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("post_reset_no_beat", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        push_word(32'h0, 32'h0, 32'h0, 32'h0, 32'h0000000F);
        offer(WF);
        chk("post_reset_start_idx", 64'(bus.out_idx), 64'd0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_word_serializer.md
Name: wide_word_serializer

Overview:
- Read side of the 132-bit pipeline/data latch: takes one 132-bit word over a valid/ready handshake and streams it out as 32-bit beats, low beat first.
- Lets wide latched bundles (four 32-bit fields plus a 4-bit flag nibble) be drained over a 32-bit path such as a bus, FIFO or UART bridge.
- One holding register plus a beat counter and a two-state FSM.

Parameters:
- WORD_W, 132, width of the input word.
- BEAT_W, 32, width of each output beat.
- NBEATS, ceil(WORD_W/BEAT_W) = 5, beats per word (derived, not overridable).
- IDX_W, ceil(log2(NBEATS)) = 3, width of the beat index (derived).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WORD_W  word to serialize.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer takes the beat this cycle.
- out_data  output  BEAT_W  current beat.
- out_idx  output  IDX_W  index of the current beat, 0..NBEATS-1.
- out_last  output  1  current beat is beat NBEATS-1.
- busy  output  1  a word is held and not yet fully sent.

Behaviour:
- States: IDLE, SEND. The holding register hold[WORD_W-1:0] and the beat counter idx[IDX_W-1:0] are the only datapath state.
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, idx=0, hold=0.
  - out_valid=0, busy=0, out_last=0, out_data=0, out_idx=0, in_ready=1 (combinational from IDLE).
- Reset mid-word discards the word. No partial beats follow reset release.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1, capture hold<=in_data, set idx<=0 and go to SEND.
- SEND:
  - out_valid=1, busy=1, out_idx=idx.
  - out_data=hold[idx*BEAT_W +: BEAT_W] for idx<NBEATS-1.
  - Final beat: out_data = hold[WORD_W-1:(NBEATS-1)*BEAT_W] zero-extended, i.e. {28'b0, hold[131:128]}.
  - out_last=(idx==NBEATS-1).
  - out_data, out_idx and out_last hold stable while out_valid=1 and out_ready=0.
  - On out_ready=1 with idx<NBEATS-1: idx<=idx+1.
  - On out_ready=1 with idx==NBEATS-1:
    - If in_valid=1: capture the new word, idx<=0, stay in SEND (back-to-back).
    - Otherwise: go to IDLE, idx<=0.
- in_ready = (state==IDLE) | (state==SEND & out_last & out_ready). This is a combinational path from out_ready to in_ready.
- Handshake rules: a transfer occurs only when valid & ready on the same rising edge. in_data is sampled only on an input transfer. Later in_data changes do not affect hold.
- Throughput: back-to-back sustains one word per NBEATS cycles with out_valid continuously high. From IDLE, the first beat appears one cycle after the input handshake.
- Simultaneous in_valid in SEND before the last beat: ignored, since in_ready=0; the producer holds its word.
- idx never exceeds NBEATS-1; no wrap beyond the last beat.

Decomposition:
- Shared package holds WORD_W/BEAT_W defaults, the NBEATS and IDX_W derivations, and the state encoding (IDLE=1'b0, SEND=1'b1).
- One sub-module, beat_select: combinational slice mux from hold and idx to out_data, including zero-extension of the final partial beat.
- The holding register is a plain enable register with enable = input transfer.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> out_valid=0, busy=0, in_ready=1, out_data=0.
- Single word, 132'hA_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, out_ready=1 -> beats AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD, 0000000A on out_idx 0..4, out_last only on idx 4, then IDLE.
- Backpressure: out_ready=0 for 3 cycles on beat 2 -> out_data stays CCCCCCCC and out_idx stays 2; in_ready=0 throughout; in_data changes are ignored.
- Back-to-back: two words, with in_valid held, out_ready=1 -> out_valid high for 10 consecutive cycles; second word's beat 0 follows the first word's beat 4 with no gap; in_ready pulses exactly on the last-beat cycle.
- Reset mid-word: reset=0 asserted after beat 1 -> outputs drop asynchronously to reset values; after release, no stale beat is emitted; the next word starts at idx 0.
- Partial last beat: word with bits 131:128=4'hF and all other bits 0 -> beats 0..3 are 0, beat 4 is 32'h0000000F.
